// File: rtl/branch_target_predictor_if.sv
// Lookup/update/statistics bundle between the fetch/resolve pipeline (master) and the BTB (slave).
interface branch_target_predictor_if #(
  parameter int ADDR_W = 16,
  parameter int HW     = 1,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] lk_pc;
  logic              lk_hit;
  logic              lk_taken;
  logic [ADDR_W-1:0] lk_target;
  logic [HW-1:0]     lk_hist;
  logic              up_valid;
  logic [ADDR_W-1:0] up_pc;
  logic [HW-1:0]     up_hist;
  logic              up_taken;
  logic [ADDR_W-1:0] up_target;
  logic              up_is_jump;
  logic              up_pred_taken;
  logic [CNT_W-1:0]  stat_updates;
  logic [CNT_W-1:0]  stat_mispred;

  modport master (
    output lk_pc, up_valid, up_pc, up_hist, up_taken, up_target, up_is_jump, up_pred_taken,
    input  lk_hit, lk_taken, lk_target, lk_hist, stat_updates, stat_mispred
  );
  modport slave (
    input  lk_pc, up_valid, up_pc, up_hist, up_taken, up_target, up_is_jump, up_pred_taken,
    output lk_hit, lk_taken, lk_target, lk_hist, stat_updates, stat_mispred
  );
endinterface

// File: rtl/branch_target_predictor.sv
// Tagged BTB with saturating direction counters and optional gshare indexing.
// Lookup is combinational on current table state; updates land at the next posedge.
module branch_target_predictor #(
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 6,
  parameter int TAG_W  = 8,
  parameter int CTR_W  = 2,
  parameter int HIST_W = 0,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst,
  branch_target_predictor_if.slave bus
);
  localparam int HW    = (HIST_W > 0) ? HIST_W : 1;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              ent_vld [DEPTH];
  logic [TAG_W-1:0]  ent_tag [DEPTH];
  logic [ADDR_W-1:0] ent_tgt [DEPTH];
  logic [CTR_W-1:0]  ent_ctr [DEPTH];
  logic [HW-1:0]     ghr;

  function automatic logic [IDX_W-1:0] index_of(input logic [ADDR_W-1:0] pc,
                                                input logic [HW-1:0] hist);
    logic [IDX_W-1:0] h;
    h = '0;
    if (HIST_W > 0) h[HW-1:0] = hist;
    return pc[IDX_W:1] ^ h;
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] pc);
    return pc[IDX_W+TAG_W:IDX_W+1];
  endfunction

  logic [IDX_W-1:0] lk_idx;
  logic             lk_hit_w;
  logic             lk_taken_w;

  assign lk_idx     = index_of(bus.lk_pc, ghr);
  assign lk_hit_w   = ent_vld[lk_idx] && (ent_tag[lk_idx] == tag_of(bus.lk_pc));
  assign lk_taken_w = lk_hit_w && ent_ctr[lk_idx][CTR_W-1];

  assign bus.lk_hit       = lk_hit_w;
  assign bus.lk_taken     = lk_taken_w;
  assign bus.lk_target    = lk_taken_w ? ent_tgt[lk_idx] : bus.lk_pc + ADDR_W'(2);
  assign bus.lk_hist      = ghr;

  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic [CTR_W-1:0] ctr_nxt;
  logic [HW:0]      ghr_shift;

  assign up_idx    = index_of(bus.up_pc, bus.up_hist);
  assign up_tag    = tag_of(bus.up_pc);
  assign up_hit    = ent_vld[up_idx] && (ent_tag[up_idx] == up_tag);
  assign ghr_shift = {ghr, bus.up_taken};

  always_comb begin
    ctr_nxt = ent_ctr[up_idx];
    if (bus.up_is_jump) begin
      ctr_nxt = CTR_MAX;
    end else if (bus.up_taken) begin
      if (ctr_nxt != CTR_MAX) ctr_nxt = ctr_nxt + CTR_W'(1);
    end else begin
      if (ctr_nxt != '0) ctr_nxt = ctr_nxt - CTR_W'(1);
    end
  end

  // Tags need no reset: a cleared valid bit masks them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_vld[i] <= 1'b0;
        ent_ctr[i] <= CTR_WNT;
        ent_tgt[i] <= '0;
      end
      ghr              <= '0;
      bus.stat_updates <= '0;
      bus.stat_mispred <= '0;
    end else if (bus.up_valid) begin
      if (up_hit) begin
        ent_ctr[up_idx] <= ctr_nxt;
        if (bus.up_taken) ent_tgt[up_idx] <= bus.up_target;
      end else if (bus.up_taken) begin
        ent_vld[up_idx] <= 1'b1;
        ent_tag[up_idx] <= up_tag;
        ent_tgt[up_idx] <= bus.up_target;
        ent_ctr[up_idx] <= bus.up_is_jump ? CTR_MAX : CTR_WT;
      end
      if ((HIST_W > 0) && !bus.up_is_jump) ghr <= ghr_shift[HW-1:0];
      if (bus.stat_updates != CNT_MAX) bus.stat_updates <= bus.stat_updates + CNT_W'(1);
      if ((bus.up_pred_taken != bus.up_taken) && (bus.stat_mispred != CNT_MAX))
        bus.stat_mispred <= bus.stat_mispred + CNT_W'(1);
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.up_pc, bus.up_hist, bus.lk_pc, ghr_shift};
endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed-vector bench: bimodal instance (defaults) and gshare instance (HIST_W=4, CNT_W=2).
module tb_branch_target_predictor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  branch_target_predictor_if #(.ADDR_W(16), .HW(1), .CNT_W(16)) bus0 ();
  branch_target_predictor_if #(.ADDR_W(16), .HW(4), .CNT_W(2))  bus1 ();

  branch_target_predictor u0 (.clk(clk), .rst(rst), .bus(bus0));
  branch_target_predictor #(.HIST_W(4), .CNT_W(2)) u1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic look0(input logic [15:0] pc);
    bus0.lk_pc = pc;
    #1;
  endtask

  task automatic look1(input logic [15:0] pc);
    bus1.lk_pc = pc;
    #1;
  endtask

  task automatic upd0(input logic [15:0] pc, input logic tk, input logic [15:0] tgt,
                      input logic jmp);
    bus0.up_valid      = 1'b1;
    bus0.up_pc         = pc;
    bus0.up_taken      = tk;
    bus0.up_target     = tgt;
    bus0.up_is_jump    = jmp;
    bus0.up_pred_taken = 1'b0;
    @(posedge clk);
    #1;
    bus0.up_valid = 1'b0;
  endtask

  task automatic upd1(input logic [15:0] pc, input logic [3:0] hist, input logic tk,
                      input logic [15:0] tgt, input logic pred);
    bus1.up_valid      = 1'b1;
    bus1.up_pc         = pc;
    bus1.up_hist       = hist;
    bus1.up_taken      = tk;
    bus1.up_target     = tgt;
    bus1.up_is_jump    = 1'b0;
    bus1.up_pred_taken = pred;
    @(posedge clk);
    #1;
    bus1.up_valid = 1'b0;
  endtask

  initial begin
    bus0.lk_pc = '0; bus0.up_valid = 0; bus0.up_pc = '0; bus0.up_hist = '0;
    bus0.up_taken = 0; bus0.up_target = '0; bus0.up_is_jump = 0; bus0.up_pred_taken = 0;
    bus1.lk_pc = '0; bus1.up_valid = 0; bus1.up_pc = '0; bus1.up_hist = '0;
    bus1.up_taken = 0; bus1.up_target = '0; bus1.up_is_jump = 0; bus1.up_pred_taken = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    look0(16'h1234);
    check("rst_hit", 32'(bus0.lk_hit), 0);
    check("rst_taken", 32'(bus0.lk_taken), 0);
    check("rst_target", 32'(bus0.lk_target), 32'h1236);
    check("rst_hist", 32'(bus0.lk_hist), 0);
    check("rst_updates", 32'(bus0.stat_updates), 0);
    check("rst_mispred", 32'(bus0.stat_mispred), 0);

    // Allocate on taken, no allocate on not-taken
    upd0(16'h0040, 1, 16'h0100, 0);
    look0(16'h0040);
    check("alloc_hit", 32'(bus0.lk_hit), 1);
    check("alloc_taken", 32'(bus0.lk_taken), 1);
    check("alloc_target", 32'(bus0.lk_target), 32'h0100);
    upd0(16'h0050, 0, 16'h0000, 0);
    look0(16'h0050);
    check("nt_noalloc_hit", 32'(bus0.lk_hit), 0);

    // Counter walk: 10 -> 01 -> 00 -> 00 -> 01 -> 10 -> 01 -> jump 11 -> 10
    look0(16'h0040);
    upd0(16'h0040, 0, 16'h0000, 0);
    check("ctr01_hit", 32'(bus0.lk_hit), 1);
    check("ctr01_taken", 32'(bus0.lk_taken), 0);
    check("ctr01_target", 32'(bus0.lk_target), 32'h0042);
    upd0(16'h0040, 0, 16'h0000, 0);
    upd0(16'h0040, 0, 16'h0000, 0);
    check("ctr00_hit", 32'(bus0.lk_hit), 1);
    check("ctr00_taken", 32'(bus0.lk_taken), 0);
    upd0(16'h0040, 1, 16'h0100, 0);
    check("sat_low_taken", 32'(bus0.lk_taken), 0);
    upd0(16'h0040, 1, 16'h0100, 0);
    check("ctr10_taken", 32'(bus0.lk_taken), 1);
    check("ctr10_target", 32'(bus0.lk_target), 32'h0100);
    upd0(16'h0040, 0, 16'h0000, 0);
    check("ctr01b_taken", 32'(bus0.lk_taken), 0);
    upd0(16'h0040, 1, 16'h0100, 1);
    check("jump_taken", 32'(bus0.lk_taken), 1);
    upd0(16'h0040, 0, 16'h0000, 0);
    check("jump_forced11", 32'(bus0.lk_taken), 1);

    // Aliasing: same index, different tag
    look0(16'h00C0);
    check("alias_miss", 32'(bus0.lk_hit), 0);
    upd0(16'h00C0, 1, 16'h0200, 0);
    check("alias_hit", 32'(bus0.lk_hit), 1);
    check("alias_target", 32'(bus0.lk_target), 32'h0200);
    look0(16'h0040);
    check("alias_evicted", 32'(bus0.lk_hit), 0);

    // Same-cycle lookup/update collision
    upd0(16'h0040, 1, 16'h0100, 0);
    bus0.up_valid = 1'b1; bus0.up_pc = 16'h0040; bus0.up_taken = 1'b1;
    bus0.up_target = 16'h0300; bus0.up_is_jump = 1'b0; bus0.up_pred_taken = 1'b0;
    #1;
    check("coll_old_target", 32'(bus0.lk_target), 32'h0100);
    @(posedge clk);
    #1 bus0.up_valid = 1'b0;
    #1;
    check("coll_new_target", 32'(bus0.lk_target), 32'h0300);
    check("stat_updates", 32'(bus0.stat_updates), 13);
    check("stat_mispred", 32'(bus0.stat_mispred), 7);

    // Reset mid-stream discards the concurrent update
    rst = 1'b1;
    bus0.up_valid = 1'b1; bus0.up_pc = 16'h0060; bus0.up_taken = 1'b1;
    bus0.up_target = 16'h0600; bus0.up_is_jump = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0; bus0.up_valid = 1'b0;
    look0(16'h0060);
    check("midrst_discard", 32'(bus0.lk_hit), 0);
    look0(16'h0040);
    check("midrst_cleared", 32'(bus0.lk_hit), 0);
    check("midrst_updates", 32'(bus0.stat_updates), 0);
    check("midrst_mispred", 32'(bus0.stat_mispred), 0);

    // gshare history and saturating stats
    look1(16'h0040);
    check("g_rst_hist", 32'(bus1.lk_hist), 0);
    upd1(16'h0010, 4'h0, 1, 16'h0400, 1);
    upd1(16'h0010, 4'h0, 1, 16'h0400, 0);
    upd1(16'h0010, 4'h0, 0, 16'h0000, 0);
    upd1(16'h0010, 4'h0, 1, 16'h0400, 0);
    check("g_hist_1101", 32'(bus1.lk_hist), 32'hD);
    upd1(16'h0040, 4'h3, 1, 16'h0500, 1);
    check("g_hist_1011", 32'(bus1.lk_hist), 32'hB);
    check("g_updates_sat", 32'(bus1.stat_updates), 3);
    check("g_mispred", 32'(bus1.stat_mispred), 2);
    look1(16'h0050);
    check("g_idx23_hit", 32'(bus1.lk_hit), 1);
    check("g_idx23_target", 32'(bus1.lk_target), 32'h0500);
    look1(16'h0040);
    check("g_idx2b_miss", 32'(bus1.lk_hit), 0);
    check("g_miss_target", 32'(bus1.lk_target), 32'h0042);
    upd1(16'h0010, 4'h0, 0, 16'h0000, 1);
    check("g_mispred3", 32'(bus1.stat_mispred), 3);
    upd1(16'h0010, 4'h0, 0, 16'h0000, 1);
    check("g_mispred_sat", 32'(bus1.stat_mispred), 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Parametrised branch target buffer with per-entry N-bit saturating direction counters and optional gshare history indexing. The IF stage uses it to choose the next fetch PC. The pipeline returns resolved branch and jump outcomes from the RF stage to train it. It generalises the fixed 1024-entry, 2-bit buffer to configurable depth, tag width, counter width and history length, and adds tag matching, allocate-on-taken, history tracking and misprediction statistics.

## Interface
- ADDR_W, 16: PC / target width.
- IDX_W, 6: index bits; table depth is 2^IDX_W.
- TAG_W, 8: tag bits. Constraint: IDX_W+TAG_W <= ADDR_W-1.
- CTR_W, 2: direction counter width, minimum 2.
- HIST_W, 0: global history length. 0 selects bimodal indexing. Otherwise gshare is used, with HIST_W <= IDX_W.
- CNT_W, 16: statistics counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- lk_pc  in  ADDR_W  fetch PC to predict.
- lk_hit  out  1  valid entry with matching tag.
- lk_taken  out  1  predicted taken.
- lk_target  out  ADDR_W  predicted next PC.
- lk_hist  out  max(HIST_W,1)  history used for this lookup. The pipeline carries it to the update.
- up_valid  in  1  resolved control-transfer this cycle.
- up_pc  in  ADDR_W  PC of the resolved instruction.
- up_hist  in  max(HIST_W,1)  the lk_hist captured at its lookup.
- up_taken  in  1  actual direction.
- up_target  in  ADDR_W  actual target.
- up_is_jump  in  1  unconditional jump.
- up_pred_taken  in  1  direction that was predicted.
- stat_updates  out  CNT_W  count of accepted updates.
- stat_mispred  out  CNT_W  count of direction mispredicts.

## Operation
- **Entry fields:** valid, tag[TAG_W], target[ADDR_W], ctr[CTR_W].
- **Index and tag:**
  - PC bit 0 is ignored (2-byte instructions).
  - idx = pc[IDX_W:1] XOR zero-extended hist; hist is forced to 0 when HIST_W=0.
  - tag = pc[IDX_W+TAG_W:IDX_W+1].
- **Lookup:**
  - Index uses lk_pc with hist = ghr.
  - lk_hit = valid && tag match.
  - lk_taken = lk_hit && ctr MSB.
  - lk_target = lk_taken ? entry target : lk_pc+2, computed modulo 2^ADDR_W.
- **Update on a hit (entry at the up_pc/up_hist index with matching tag):**
  - If up_is_jump, ctr is set to all-ones.
  - Otherwise ctr is incremented when up_taken and decremented when not, saturating at all-ones and at 0.
  - target is written with up_target only when up_taken.
- **Update on a miss:**
  - If up_taken, allocate or replace the entry: valid=1, tag, target=up_target.
  - The new ctr is all-ones for a jump, otherwise 2^(CTR_W-1) (weakly taken).
  - If not taken, the table is unchanged.
- **GHR (HIST_W>0):** on up_valid && !up_is_jump, ghr <= {ghr[HIST_W-2:0], up_taken}. This is non-speculative. When HIST_W=0, ghr and lk_hist are constant 0.
- **Statistics:**
  - stat_updates increments on every up_valid.
  - stat_mispred increments on up_valid && (up_pred_taken != up_taken).
  - Both saturate at all-ones and never wrap.

## Timing
- Lookup is combinational from lk_pc to all lk_* outputs with zero cycles of latency. It reflects table state as of the last clock edge.
- An update is sampled at the posedge where up_valid=1 and is visible to lookups from the next cycle.
- When a lookup and an update hit the same entry in the same cycle, the lookup returns the pre-update contents.
- Back-to-back updates to the same entry compose: the second sees the first's result.
- **Reset:** on a posedge with rst=1, all entries get valid=0, ctr=2^(CTR_W-1)-1 (weakly not taken) and target=0. ghr and both stat counters are cleared to 0, and up_valid is ignored that cycle.
- **Reset values of outputs:** lk_hit=0, lk_taken=0, lk_target=lk_pc+2, lk_hist=0, stat_updates=0, stat_mispred=0.
- A reset asserted mid-stream discards any update presented in the same cycle.

## Test plan
- **Reset:** after rst, looking up lk_pc=0x1234 gives lk_hit=0, lk_taken=0, lk_target=0x1236, and both stats read 0.
- **Allocate (defaults):** an update with pc=0x0040, taken, target=0x0100 gives, on the next cycle, lookup 0x0040 -> hit=1, taken=1, target=0x0100. A not-taken update with pc=0x0050 leaves lookup 0x0050 with hit=0.
- **Counter saturation:** three not-taken updates to 0x0040 move ctr 10 -> 01 -> 00 -> 00. taken=0 after the first update and hit stays 1. Two taken updates then move ctr 01 (taken=0) -> 10 (taken=1). A jump update forces ctr to 11.
- **Aliasing:** 0x00C0 has the same index as 0x0040 but a different tag. Lookup 0x00C0 gives hit=0. A taken update at 0x00C0 with target 0x0200 replaces the entry, after which 0x0040 misses.
- **Same-cycle collision:** update 0x0040 (taken, target 0x0300) while looking up 0x0040 in the same cycle. The lookup returns the old target 0x0100, and the next cycle returns 0x0300.
- **gshare and stats (HIST_W=4, CNT_W=2):**
  - Updates with outcomes T, T, N, T give ghr=4'b1101, and lk_hist matches.
  - Update pc=0x0040 with up_hist=4'b0011 writes index 0x20^0x03=0x23.
  - Five updates that include two direction mismatches give stat_updates=3 (saturated) and stat_mispred=2.
